fetch_queue_stage: RTL and testbench

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

---
 rtl/fetch_queue_stage_if.sv | 28 ++
 rtl/fetch_queue_stage.sv | 99 +++++++++
 tb/tb_fetch_queue_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bundle: predictor/IMEM inputs, decode redirect, and the decoupling
// queue's head entry presented to decode.
interface fetch_queue_stage_if;
  logic [31:0] pc_f;
  logic        fetch_en;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic [31:0] instr_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pred_pc;
  logic        d_pred_taken;
  logic [15:0] redirect_cnt;

  modport master (
    output pc_f, fetch_en, d_valid, d_pc, d_instr, d_pred_pc, d_pred_taken, redirect_cnt,
    input  predict_pc, predict_taken, instr_f, redirect, redirect_pc, d_ready
  );

  modport slave (
    input  pc_f, fetch_en, d_valid, d_pc, d_instr, d_pred_pc, d_pred_taken, redirect_cnt,
    output predict_pc, predict_taken, instr_f, redirect, redirect_pc, d_ready
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a small circular queue decoupling instruction fetch from decode.
// The next PC always comes from the predictor or a decode redirect; no PC adder lives here.
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input logic                 clk,
  input logic                 rst,
  fetch_queue_stage_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pred_pc;
    logic        pred_taken;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [31:0]        pc_q;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        redirect_cnt_q;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  entry_t             head;
  entry_t             new_entry;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full queue can still accept a fetch when decode drains the head in the same cycle.
  assign pop  = !empty && bus.d_ready;
  assign push = !rst && !bus.redirect && (!full || pop);

  assign new_entry = '{pc: pc_q, instr: bus.instr_f,
                       pred_pc: bus.predict_pc, pred_taken: bus.predict_taken};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      pc_q   <= bus.redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q   <= bus.predict_pc;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is left unreset; slots are only observed once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
    end else if (bus.redirect && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign head = mem[rd_ptr];

  assign bus.pc_f         = pc_q;
  assign bus.fetch_en     = push;
  assign bus.d_valid      = !empty;
  assign bus.d_pc         = head.pc;
  assign bus.d_instr      = head.instr;
  assign bus.d_pred_pc    = head.pred_pc;
  assign bus.d_pred_taken = head.pred_taken;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_fetch_queue_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 4;

  logic clk;
  logic rst;

  fetch_queue_stage_if bus ();

  fetch_queue_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        use_seq;
  logic [31:0] man_pc;
  logic        man_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Environment: combinational instruction memory and a sequential/override predictor.
  always_comb begin
    bus.instr_f       = imem(bus.pc_f);
    bus.predict_pc    = use_seq ? bus.pc_f + 32'd4 : man_pc;
    bus.predict_taken = use_seq ? 1'b0 : man_taken;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC, an ordered list of pending entries, redirect tally.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pred_pc;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_cnt;
  bit          model_ok = 0;

  function automatic bit model_fetch();
    return !rst && !bus.redirect && ((mq.size() < DEPTH) || (mq.size() > 0 && bus.d_ready));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RESET_PC;
      mq.delete();
      m_cnt = 0;
      model_ok = 1;
    end else if (model_ok) begin
      if (bus.redirect) begin
        m_pc = bus.redirect_pc;
        mq.delete();
        if (m_cnt < 65535) m_cnt++;
      end else begin
        bit          do_pop;
        bit          do_push;
        logic [31:0] pred;
        logic        tk;
        do_pop  = (mq.size() > 0) && bus.d_ready;
        do_push = (mq.size() < DEPTH) || do_pop;
        pred    = use_seq ? m_pc + 32'd4 : man_pc;
        tk      = use_seq ? 1'b0 : man_taken;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{pc: m_pc, instr: imem(m_pc), pred_pc: pred, taken: tk});
          m_pc = pred;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check_output("pc_f", bus.pc_f, m_pc);
      check_output("fetch_en", 32'(bus.fetch_en), 32'(model_fetch()));
      check_output("d_valid", 32'(bus.d_valid), 32'(mq.size() > 0));
      check_output("redirect_cnt", 32'(bus.redirect_cnt), 32'(m_cnt));
      if (mq.size() > 0) begin
        check_output("d_pc", bus.d_pc, mq[0].pc);
        check_output("d_instr", bus.d_instr, mq[0].instr);
        check_output("d_pred_pc", bus.d_pred_pc, mq[0].pred_pc);
        check_output("d_pred_taken", 32'(bus.d_pred_taken), 32'(mq[0].taken));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    bus.d_ready     = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_output("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check_output("rst_pc_f", bus.pc_f, RESET_PC);
    check_output("rst_fetch_en", 32'(bus.fetch_en), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    use_seq   = 1'b1;
    man_pc    = '0;
    man_taken = 1'b0;
    apply_stimulus(1'b1, 1'b0, '0);

    // Sequential fetch with decode always ready: d_pc trails pc_f by one.
    do_reset();
    #1;
    check_output("seq0_pc_f", bus.pc_f, 32'hBFC0_0000);
    check_output("seq0_d_valid", 32'(bus.d_valid), 32'd0);
    check_output("seq0_fetch_en", 32'(bus.fetch_en), 32'd1);
    tick();
    check_output("seq1_pc_f", bus.pc_f, 32'hBFC0_0004);
    check_output("seq1_d_valid", 32'(bus.d_valid), 32'd1);
    check_output("seq1_d_pc", bus.d_pc, 32'hBFC0_0000);
    tick();
    check_output("seq2_pc_f", bus.pc_f, 32'hBFC0_0008);
    check_output("seq2_d_pc", bus.d_pc, 32'hBFC0_0004);

    // Stalled decode fills the queue, then a simultaneous pop/push at full.
    apply_stimulus(1'b0, 1'b0, '0);
    do_reset();
    repeat (4) tick();
    check_output("full_fetch_en", 32'(bus.fetch_en), 32'd0);
    check_output("full_pc_f", bus.pc_f, 32'hBFC0_0010);
    repeat (2) tick();
    check_output("full_hold_pc_f", bus.pc_f, 32'hBFC0_0010);
    check_output("full_d_pc", bus.d_pc, 32'hBFC0_0000);
    apply_stimulus(1'b1, 1'b0, '0);
    #1;
    check_output("full_pop_fetch_en", 32'(bus.fetch_en), 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b0, '0);
    #1;
    check_output("full_after_d_pc", bus.d_pc, 32'hBFC0_0004);
    check_output("full_after_pc_f", bus.pc_f, 32'hBFC0_0014);
    check_output("full_after_fetch_en", 32'(bus.fetch_en), 32'd0);

    // Redirect flushes a three-entry queue.
    do_reset();
    repeat (3) tick();
    check_output("pre_redir_d_valid", 32'(bus.d_valid), 32'd1);
    apply_stimulus(1'b0, 1'b1, 32'h0040_0100);
    tick();
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("redir_d_valid", 32'(bus.d_valid), 32'd0);
    check_output("redir_pc_f", bus.pc_f, 32'h0040_0100);
    check_output("redir_cnt", 32'(bus.redirect_cnt), 32'd1);

    // Taken prediction recorded in the queued entry.
    apply_stimulus(1'b0, 1'b1, 32'h0040_0010);
    tick();
    apply_stimulus(1'b0, 1'b0, '0);
    use_seq   = 1'b0;
    man_pc    = 32'h0040_0200;
    man_taken = 1'b1;
    tick();
    use_seq   = 1'b1;
    man_taken = 1'b0;
    check_output("taken_pc_f", bus.pc_f, 32'h0040_0200);
    check_output("taken_d_pc", bus.d_pc, 32'h0040_0010);
    check_output("taken_d_pred_taken", 32'(bus.d_pred_taken), 32'd1);
    check_output("taken_d_pred_pc", bus.d_pred_pc, 32'h0040_0200);
    check_output("taken_cnt", 32'(bus.redirect_cnt), 32'd2);

    // Reset wins over a simultaneous redirect.
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b1, 32'h1111_2220);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, '0);
    check_output("rst_redir_pc_f", bus.pc_f, RESET_PC);
    check_output("rst_redir_cnt", 32'(bus.redirect_cnt), 32'd0);

    // Saturation of the redirect counter.
    apply_stimulus(1'b1, 1'b1, 32'h0000_8000);
    repeat (65536) tick();
    check_output("sat_cnt", 32'(bus.redirect_cnt), 32'h0000_FFFF);
    repeat (2) tick();
    check_output("sat_hold_cnt", 32'(bus.redirect_cnt), 32'h0000_FFFF);
    apply_stimulus(1'b1, 1'b0, '0);

    // Mixed pattern exercising pointer wrap, partial occupancy and predictor overrides.
    for (int i = 0; i < 64; i++) begin
      logic [7:0] rdy_pat;
      rdy_pat   = 8'b1011_0010;
      use_seq   = (i % 3) != 0;
      man_pc    = 32'h0000_1000 + 32'(i * 8);
      man_taken = i[0];
      apply_stimulus(rdy_pat[i % 8], (i == 37), 32'h0000_2000);
      tick();
    end
    apply_stimulus(1'b1, 1'b0, '0);
    repeat (6) tick();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
